instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Serial program loader: assembles big-endian 32-bit words from a byte stream
// and writes them to instruction memory, stopping on a terminator or an error.
`timescale 1ns/1ps
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;

    localparam logic [31:0]     TERMINATOR = 32'hFFFF_FFFF;
    localparam logic [ADDR_W:0] MEM_FULL   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] shreg;
    logic [31:0] next_word;
    logic        next_writable;

    function automatic logic opcode_ok(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b010001, 6'b001100, 6'b000100,
            6'b000101, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b001111, 6'b100011, 6'b100111, 6'b001101, 6'b101000,
            6'b101001, 6'b001010, 6'b001011, 6'b101011, 6'b001110:
                opcode_ok = 1'b1;
            default:
                opcode_ok = 1'b0;
        endcase
    endfunction

    // The write strobe is registered, so the verdict on the completed word is
    // taken on the edge that accepts its last byte; WRITE re-checks the stored word.
    assign next_word     = {shreg[23:0], rx_data};
    assign next_writable = (next_word != TERMINATOR) && opcode_ok(next_word[31:26])
                           && (word_count != MEM_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            shreg      <= 32'd0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 2'b00;
            word_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    imem_we <= 1'b0;
                    if (start) begin
                        state      <= COLLECT;
                        byte_cnt   <= 2'd0;
                        imem_addr  <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        err        <= 2'b00;
                        rx_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        shreg    <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            rx_ready <= 1'b0;
                            if (next_writable) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= next_word;
                                imem_addr  <= word_count[ADDR_W-1:0];
                            end
                        end
                    end
                end
                WRITE: begin
                    imem_we <= 1'b0;
                    if (shreg == TERMINATOR) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= DONE;
                    end else if (!opcode_ok(shreg[31:26])) begin
                        err      <= 2'b01;
                        cpu_hold <= 1'b0;
                        state    <= ERROR;
                    end else if (word_count == MEM_FULL) begin
                        err      <= 2'b10;
                        cpu_hold <= 1'b0;
                        state    <= ERROR;
                    end else begin
                        word_count <= word_count + ONE;
                        rx_ready   <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    imem_we  <= 1'b0;
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader, built with a 4-word memory
// so the overflow path is reachable.
`timescale 1ns/1ps
module tb_instr_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   word_count;

    int tests    = 0;
    int failures = 0;
    int wr_n     = 0;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we === 1'b1)
            wr_n++;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for the loader to be ready, then hands it one byte.
    task automatic apply_stimulus(input logic [7:0] b);
        for (int i = 0; i < 20 && rx_ready !== 1'b1; i++)
            tick();
        if (rx_ready !== 1'b1) begin
            failures++;
            $error("[TB] FAIL rx_ready_wait: observed %b expected 1", rx_ready);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        apply_stimulus(w[31:24]);
        apply_stimulus(w[23:16]);
        apply_stimulus(w[15:8]);
        apply_stimulus(w[7:0]);
    endtask

    logic [7:0] stream [8];
    int         wr_base;
    int         idx;
    logic       rdy_pre;

    initial begin
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        check_output("rst rx_ready", rx_ready, 0);
        check_output("rst imem_we", imem_we, 0);
        check_output("rst imem_addr", imem_addr, 0);
        check_output("rst imem_wdata", imem_wdata, 0);
        check_output("rst cpu_hold", cpu_hold, 0);
        check_output("rst done", done, 0);
        check_output("rst err", err, 0);
        check_output("rst word_count", word_count, 0);
        reset = 1'b0;
        tick();
        check_output("idle rx_ready", rx_ready, 0);

        // One word followed by the terminator
        wr_base = wr_n;
        pulse_start();
        check_output("t1 rx_ready", rx_ready, 1);
        check_output("t1 cpu_hold", cpu_hold, 1);
        send_word(32'h2008_0005);
        check_output("t1 we", imem_we, 1);
        check_output("t1 addr", imem_addr, 0);
        check_output("t1 wdata", imem_wdata, 32'h2008_0005);
        check_output("t1 write rx_ready", rx_ready, 0);
        send_word(32'hFFFF_FFFF);
        check_output("t1 term we", imem_we, 0);
        tick();
        check_output("t1 done", done, 1);
        check_output("t1 err", err, 0);
        check_output("t1 word_count", word_count, 1);
        check_output("t1 cpu_hold", cpu_hold, 0);
        check_output("t1 writes", wr_n - wr_base, 1);

        // Unsupported opcode 111111
        wr_base = wr_n;
        pulse_start();
        check_output("t2 done cleared", done, 0);
        send_word(32'hFC00_0000);
        check_output("t2 we", imem_we, 0);
        tick();
        tick();
        tick();
        check_output("t2 err", err, 2'b01);
        check_output("t2 rx_ready", rx_ready, 0);
        check_output("t2 cpu_hold", cpu_hold, 0);
        check_output("t2 word_count", word_count, 0);
        check_output("t2 writes", wr_n - wr_base, 0);

        // Fill the 4-word memory, then overflow; start pulses mid-load are ignored
        wr_base = wr_n;
        pulse_start();
        check_output("t3 err cleared", err, 0);
        for (int w = 0; w < 5; w++) begin
            if (w == 1)
                pulse_start();
            apply_stimulus(8'h8C);
            apply_stimulus(8'h01);
            if (w == 2)
                pulse_start();
            apply_stimulus(8'h00);
            apply_stimulus(8'h00);
            if (w < 4) begin
                check_output($sformatf("t3 w%0d we", w), imem_we, 1);
                check_output($sformatf("t3 w%0d addr", w), imem_addr, w);
                check_output($sformatf("t3 w%0d wdata", w), imem_wdata, 32'h8C01_0000);
            end else begin
                check_output("t3 overflow we", imem_we, 0);
            end
        end
        tick();
        check_output("t3 err", err, 2'b10);
        check_output("t3 word_count", word_count, 4);
        check_output("t3 writes", wr_n - wr_base, 4);

        // Streaming with rx_valid held high: writes land in cycles 5 and 10
        stream = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h34, 8'h56, 8'h78, 8'h9A};
        pulse_start();
        idx = 0;
        for (int c = 1; c <= 10; c++) begin
            check_output($sformatf("t4 c%0d we", c), imem_we, (c == 5 || c == 10) ? 1 : 0);
            check_output($sformatf("t4 c%0d rx_ready", c), rx_ready, (c == 5 || c == 10) ? 0 : 1);
            if (c == 5) begin
                check_output("t4 wdata0", imem_wdata, 32'h0011_2233);
                check_output("t4 addr0", imem_addr, 0);
            end
            if (c == 10) begin
                check_output("t4 wdata1", imem_wdata, 32'h3456_789A);
                check_output("t4 addr1", imem_addr, 1);
            end
            rx_valid = (idx < 8);
            rx_data  = stream[idx < 8 ? idx : 7];
            rdy_pre  = rx_ready;
            tick();
            if (rdy_pre && rx_valid)
                idx++;
        end
        rx_valid = 1'b0;
        check_output("t4 bytes taken", idx, 8);
        check_output("t4 word_count", word_count, 2);

        // Asynchronous reset mid-word, then a clean reload
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        #2;
        reset = 1'b1;
        #1;
        check_output("t5 async rx_ready", rx_ready, 0);
        check_output("t5 async cpu_hold", cpu_hold, 0);
        check_output("t5 async word_count", word_count, 0);
        check_output("t5 async imem_wdata", imem_wdata, 0);
        check_output("t5 async imem_addr", imem_addr, 0);
        #2;
        reset = 1'b0;
        tick();
        wr_base = wr_n;
        pulse_start();
        send_word(32'hAC01_0007);
        check_output("t5 we", imem_we, 1);
        check_output("t5 addr", imem_addr, 0);
        check_output("t5 wdata", imem_wdata, 32'hAC01_0007);
        tick();
        check_output("t5 word_count", word_count, 1);
        check_output("t5 writes", wr_n - wr_base, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
